// File: rtl/rect_fill_engine_pkg.sv
// Shared definitions for the rectangle fill engine: framebuffer geometry
// defaults, arbiter op encoding, FSM states and the latched command record.
package rect_fill_engine_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;

  localparam logic ARB_OP_READ  = 1'b0;
  localparam logic ARB_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [9:0]  w;
    logic [8:0]  h;
    logic [11:0] color;
  } cmd_t;

  // One RGB444 pixel occupies the low 12 bits of a framebuffer word.
  function automatic logic [31:0] rgb444_word(input logic [11:0] c);
    return {20'b0, c};
  endfunction

endpackage

// File: rtl/rect_fill_engine_clip.sv
// rect_clip: combinational clipping of a fill rectangle against the
// framebuffer. x_end/y_end are exclusive bounds clamped to the framebuffer;
// empty flags a rectangle with no visible pixel; oob flags any overhang.
module rect_clip
  import rect_fill_engine_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  output logic [10:0] x_end,
  output logic [10:0] y_end,
  output logic        empty,
  output logic        oob
);

  localparam logic [10:0] FBW = 11'(FB_WIDTH);
  localparam logic [10:0] FBH = 11'(FB_HEIGHT);

  logic [10:0] x_sum;
  logic [10:0] y_sum;

  // Sum in 11 bits so x+w and y+h never wrap, then clamp to the framebuffer.
  always_comb begin
    x_sum = {1'b0, x} + {1'b0, w};
    y_sum = {2'b0, y} + {2'b0, h};
    x_end = (x_sum > FBW) ? FBW : x_sum;
    y_end = (y_sum > FBH) ? FBH : y_sum;
    empty = (w == 10'd0) || (h == 9'd0) || ({1'b0, x} >= FBW) || ({2'b0, y} >= FBH);
    oob   = (x_sum > FBW) || (y_sum > FBH);
  end

endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: accepts one fill command, clips it, then issues one word
// write per pixel on the arbiter's rectangle-fill port.
// Build option: define RECT_FILL_CLIP_EN to clip overhanging rectangles;
// without it, any overhanging (non-empty) command is rejected with an err pulse.
module rect_fill_engine
  import rect_fill_engine_pkg::*;
#(
  parameter int          FB_WIDTH  = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT = FB_HEIGHT_DEF,
  parameter logic [16:0] FB_BASE   = 17'h00000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        enable,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [11:0] cmd_color,
  input  logic        cmd_rts,
  output logic        cmd_rtr,
  output logic [16:0] fill_addr,
  output logic [31:0] fill_wrdata,
  output logic        fill_op,
  output logic        fill_rts,
  input  logic        fill_rtr,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef RECT_FILL_CLIP_EN
  localparam logic REJECT_OOB = 1'b0;
`else
  localparam logic REJECT_OOB = 1'b1;
`endif

  localparam logic [16:0] ROW_STRIDE = 17'(FB_WIDTH);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [10:0] x_end_q, x_end_d, y_end_q, y_end_d;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic [16:0] row_base_q, row_base_d;
  logic [16:0] fill_addr_q, fill_addr_d;
  logic [31:0] fill_wrdata_q, fill_wrdata_d;
  logic        fill_rts_q, fill_rts_d, fill_op_q, fill_op_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [10:0] clip_x_end, clip_y_end;
  logic        clip_empty, clip_oob;
  logic [16:0] setup_base;
  logic        xfc, last_col, last_row;

  rect_clip #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_clip (
    .x     (cmd_q.x),
    .y     (cmd_q.y),
    .w     (cmd_q.w),
    .h     (cmd_q.h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty),
    .oob   (clip_oob)
  );

  assign cmd_rtr     = (state_q == ST_IDLE) && enable;
  assign fill_addr   = fill_addr_q;
  assign fill_wrdata = fill_wrdata_q;
  assign fill_op     = fill_op_q;
  assign fill_rts    = fill_rts_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  // Handshake decode, pixel position flags and the first-row base address.
  always_comb begin
    xfc        = fill_rts_q && fill_rtr;
    last_col   = (col_q == x_end_q - 11'd1);
    last_row   = (row_q == y_end_q - 11'd1);
    setup_base = FB_BASE + 17'(cmd_q.y) * ROW_STRIDE;
  end

  // Next-state: command latch, clip decision, raster walk and status pulses.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    x_end_d       = x_end_q;
    y_end_d       = y_end_q;
    col_d         = col_q;
    row_d         = row_q;
    row_base_d    = row_base_q;
    fill_addr_d   = fill_addr_q;
    fill_wrdata_d = fill_wrdata_q;
    fill_rts_d    = fill_rts_q;
    fill_op_d     = fill_op_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_rts && cmd_rtr) begin
          cmd_d   = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        x_end_d = clip_x_end;
        y_end_d = clip_y_end;
        // Empty wins over overhang: an empty command always completes with done.
        if (clip_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (REJECT_OOB && clip_oob) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d       = ST_WRITE;
          row_base_d    = setup_base;
          col_d         = {1'b0, cmd_q.x};
          row_d         = {2'b0, cmd_q.y};
          fill_addr_d   = setup_base + 17'(cmd_q.x);
          fill_wrdata_d = rgb444_word(cmd_q.color);
          fill_rts_d    = 1'b1;
          fill_op_d     = ARB_OP_WRITE;
        end
      end
      ST_WRITE: begin
        // Request fields only move on a transfer, so stalls hold them stable.
        if (xfc) begin
          if (last_col && last_row) begin
            state_d    = ST_DONE;
            fill_rts_d = 1'b0;
            fill_op_d  = ARB_OP_READ;
            done_d     = 1'b1;
          end else if (last_col) begin
            col_d       = {1'b0, cmd_q.x};
            row_d       = row_q + 11'd1;
            row_base_d  = row_base_q + ROW_STRIDE;
            fill_addr_d = row_base_q + ROW_STRIDE + 17'(cmd_q.x);
          end else begin
            col_d       = col_q + 11'd1;
            fill_addr_d = fill_addr_q + 17'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      row_base_q    <= '0;
      fill_addr_q   <= '0;
      fill_wrdata_q <= '0;
      fill_rts_q    <= 1'b0;
      fill_op_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      x_end_q       <= x_end_d;
      y_end_q       <= y_end_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_base_q    <= row_base_d;
      fill_addr_q   <= fill_addr_d;
      fill_wrdata_q <= fill_wrdata_d;
      fill_rts_q    <= fill_rts_d;
      fill_op_q     <= fill_op_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: a pixel-list model of each
// command feeds a scoreboard checked on every transfer, plus literal pins.
module tb_rect_fill_engine;

`ifdef RECT_FILL_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0, rst_ = 1'b0, enable = 1'b1;
  logic [9:0]  cmd_x = '0, cmd_w = '0;
  logic [8:0]  cmd_y = '0, cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        cmd_rts = 1'b0, cmd_rtr;
  logic [16:0] fill_addr;
  logic [31:0] fill_wrdata;
  logic        fill_op, fill_rts, fill_rtr = 1'b1, busy, done, err;

  rect_fill_engine dut (
    .clk(clk), .rst_(rst_), .enable(enable),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_rts(cmd_rts), .cmd_rtr(cmd_rtr),
    .fill_addr(fill_addr), .fill_wrdata(fill_wrdata), .fill_op(fill_op),
    .fill_rts(fill_rts), .fill_rtr(fill_rtr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int exp_q[$];
  int exp_d_q[$];
  int log_q[$];
  int rtr_mode = 0;
  int done_cnt = 0, err_cnt = 0, xfc_cnt = 0;
  int first_rts_cyc = -1, done_cyc = -1, err_cyc = -1, last_xfc_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Arbiter grant: 0 = always, 1 = random, 2 = withheld.
  initial forever begin
    @(posedge clk);
    #1;
    case (rtr_mode)
      0: fill_rtr = 1'b1;
      1: fill_rtr = 1'($urandom_range(0, 1));
      default: fill_rtr = 1'b0;
    endcase
  end

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_) begin
      if (prev_stall) begin
        chk("hold_rts", fill_rts, 1);
        chk("hold_addr", fill_addr, prev_addr);
        chk("hold_data", fill_wrdata, prev_data);
      end
      if (fill_rts) chk("op_write", fill_op, 1);
      chk("rtr_busy_excl", cmd_rtr && busy, 0);
      chk("rts_without_busy", fill_rts && !busy, 0);
      if (fill_rts && first_rts_cyc < 0) first_rts_cyc = cyc;
      if (fill_rts && fill_rtr) begin
        xfc_cnt++;
        last_xfc_cyc = cyc;
        log_q.push_back(int'(fill_addr));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d with no pixel outstanding", fill_addr);
        end else begin
          chk("wr_addr", fill_addr, exp_q.pop_front());
          chk("wr_data", fill_wrdata, exp_d_q.pop_front());
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
    end
    prev_stall = fill_rts && !fill_rtr && rst_;
    prev_addr  = fill_addr;
    prev_data  = fill_wrdata;
  end

  // Reference: raster list of visible pixels, or rejection when clipping is off.
  task automatic model(input int x, y, w, h, c, output int n, output bit e);
    n = 0;
    e = 1'b0;
    if (w == 0 || h == 0 || x >= 320 || y >= 240) return;
    if (!CLIP && (x + w > 320 || y + h > 240)) begin e = 1'b1; return; end
    for (int r = y; r < y + h && r < 240; r++)
      for (int cc = x; cc < x + w && cc < 320; cc++) begin
        exp_q.push_back(r * 320 + cc);
        exp_d_q.push_back(c);
        n++;
      end
  endtask

  task automatic clear_stats();
    done_cnt = 0; err_cnt = 0; xfc_cnt = 0;
    first_rts_cyc = -1; done_cyc = -1; err_cyc = -1; last_xfc_cyc = -1;
    log_q.delete();
  endtask

  task automatic wait_accept(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_rtr) begin got = 1'b1; break; end
    end
    chk("accept_seen", got, 1);
  endtask

  task automatic wait_finish(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done || err) begin got = 1'b1; break; end
    end
    chk("finish_seen", got, 1);
  endtask

  // Issue one command (entered at posedge+1) and check its whole outcome.
  task automatic run_cmd(input int x, y, w, h, c, input int mode, input bit keep_en);
    int n, acc;
    bit e, got;
    model(x, y, w, h, c, n, e);
    clear_stats();
    rtr_mode  = mode;
    cmd_x     = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
    cmd_color = 12'(c);
    cmd_rts   = 1'b1;
    wait_accept(got);
    acc = cyc + 1;
    @(posedge clk);
    #1 cmd_rts = 1'b0;
    if (!keep_en) enable = 1'b0;
    if (got) begin
      wait_finish(got);
      if (got && done) begin
        chk("done_rtr_low", cmd_rtr, 0);
        chk("done_rts_low", fill_rts, 0);
      end
      @(negedge clk);
      if (got) chk("rtr_back", cmd_rtr, enable);
      enable = 1'b1;
      chk("done_cnt", done_cnt, e ? 0 : 1);
      chk("err_cnt", err_cnt, e ? 1 : 0);
      chk("xfc_cnt", xfc_cnt, n);
      chk("exp_left", exp_q.size(), 0);
      if (e) chk("err_lat", err_cyc, acc + 1);
      else if (n == 0) begin
        chk("empty_done_lat", done_cyc, acc + 1);
        chk("empty_no_rts", first_rts_cyc, -1);
      end else begin
        chk("first_rts_lat", first_rts_cyc, acc + 1);
        chk("done_after_last", done_cyc, last_xfc_cyc + 1);
        if (mode == 0) chk("burst_len", done_cyc, acc + n + 1);
      end
    end
    exp_q.delete();
    exp_d_q.delete();
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lit1[8] = '{0, 1, 2, 3, 320, 321, 322, 323};
    int na, nb, x, y;
    bit ea, eb, got;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rts", fill_rts, 0);
    chk("rst_op", fill_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", fill_addr, 0);
    chk("rst_data", fill_wrdata, 0);
    chk("rst_rtr", cmd_rtr, 1);
    @(posedge clk);
    #1 rst_ = 1'b1;

    // 1: basic 4x2 fill, grant always
    run_cmd(0, 0, 4, 2, 12'hF00, 0, 1);
    chk("t1_nwrites", log_q.size(), 8);
    for (int i = 0; i < 8; i++) if (i < log_q.size()) chk("t1_addr", log_q[i], lit1[i]);

    // 2: same command, random stalls
    run_cmd(0, 0, 4, 2, 12'hF00, 1, 1);
    chk("t2_nwrites", log_q.size(), 8);
    for (int i = 0; i < 8; i++) if (i < log_q.size()) chk("t2_addr", log_q[i], lit1[i]);

    // 3: overhanging bottom-right corner
    run_cmd(318, 239, 5, 3, 12'h0AB, 0, 1);
    chk("t3_nwrites", log_q.size(), CLIP ? 2 : 0);
    chk("t3_err", err_cnt, CLIP ? 0 : 1);
    if (CLIP && log_q.size() == 2) begin
      chk("t3_addr0", log_q[0], 76798);
      chk("t3_addr1", log_q[1], 76799);
    end

    // 4: empty commands
    run_cmd(5, 5, 0, 3, 12'h123, 0, 1);
    run_cmd(400, 5, 4, 4, 12'h456, 0, 1);

    // enable gates acceptance
    enable = 1'b0; cmd_x = 10'd1; cmd_y = 9'd1; cmd_w = 10'd2; cmd_h = 9'd2; cmd_rts = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("en_low_rtr", cmd_rtr, 0);
      chk("en_low_busy", busy, 0);
    end
    @(posedge clk);
    #1 cmd_rts = 1'b0; enable = 1'b1;

    // enable dropped mid-fill does not stop the fill
    run_cmd(100, 10, 6, 2, 12'h0F0, 0, 0);

    // 5: reset during a stalled WRITE
    clear_stats();
    rtr_mode = 2;
    cmd_x = 10'd10; cmd_y = 9'd5; cmd_w = 10'd20; cmd_h = 9'd3; cmd_color = 12'hABC;
    cmd_rts = 1'b1;
    wait_accept(got);
    @(posedge clk);
    #1 cmd_rts = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fill_rts) begin got = 1'b1; break; end
    end
    chk("t5_rts_seen", got, 1);
    @(posedge clk);
    #1 rst_ = 1'b0;
    @(posedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    chk("t5_rts_after_rst", fill_rts, 0);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_rtr_after_rst", cmd_rtr, 1);
    chk("t5_no_xfc", xfc_cnt, 0);
    @(posedge clk);
    #1;
    run_cmd(7, 3, 5, 2, 12'h321, 1, 1);

    // 6: back-to-back with cmd_rts held
    clear_stats();
    rtr_mode = 0;
    model(20, 20, 3, 2, 12'h111, na, ea);
    model(300, 100, 4, 1, 12'h222, nb, eb);
    cmd_x = 10'd20; cmd_y = 9'd20; cmd_w = 10'd3; cmd_h = 9'd2; cmd_color = 12'h111;
    cmd_rts = 1'b1;
    wait_accept(got);
    @(posedge clk);
    #1 cmd_x = 10'd300; cmd_y = 9'd100; cmd_w = 10'd4; cmd_h = 9'd1; cmd_color = 12'h222;
    wait_finish(got);
    chk("t6_done_a_rts", fill_rts, 0);
    @(negedge clk);
    chk("t6_rtr_after_a", cmd_rtr, 1);
    @(posedge clk);
    #1 cmd_rts = 1'b0;
    @(negedge clk);
    chk("t6_busy_b", busy, 1);
    wait_finish(got);
    @(negedge clk);
    chk("t6_done_cnt", done_cnt, 2);
    chk("t6_xfc_cnt", xfc_cnt, na + nb);
    chk("t6_exp_left", exp_q.size(), 0);
    exp_q.delete();
    exp_d_q.delete();
    @(posedge clk);
    #1;

    // randomized commands, biased toward the right/bottom edges
    for (int k = 0; k < 24; k++) begin
      x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(305, 330)) : int'($urandom_range(0, 300));
      y = ($urandom_range(0, 1) != 0) ? int'($urandom_range(232, 245)) : int'($urandom_range(0, 230));
      run_cmd(x, y, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
